// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALUop encodings and the control bundle shared by the control unit
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic       RegDst;
    logic       ALUsrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       BranchNe;
    logic [1:0] ALUop;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/mips_control_decode.sv
// control_decode: combinational opcode-to-control-bundle decoder
// Ports: opcode (instruction bits [31:26]) in, ctrl (control bundle) out.
module control_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);
  // Starting from the NOP bundle keeps every don't-care field at 0; an X/Z opcode
  // matches no item and falls through to NOP.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.ALUop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl.ALUsrc   = 1'b1;
        ctrl.MemtoReg = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.MemRead  = 1'b1;
        ctrl.ALUop    = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.ALUsrc   = 1'b1;
        ctrl.MemWrite = 1'b1;
        ctrl.ALUop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.Branch = 1'b1;
        ctrl.ALUop  = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl.Branch   = 1'b1;
        ctrl.BranchNe = 1'b1;
        ctrl.ALUop    = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.ALUsrc   = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.ALUop    = ALUOP_ADD;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end
endmodule

// File: rtl/mips_control.sv
// mips_control: registered main control unit feeding the ID/EX pipeline register
// Ports: clk, rst_n (async active-low), opcode in; RegDst, Branch, BranchNe, MemRead,
// MemtoReg, ALUop[1:0], MemWrite, ALUsrc, RegWrite out (one cycle after opcode).
module mips_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       RegDst,
  output logic       Branch,
  output logic       BranchNe,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic [1:0] ALUop,
  output logic       MemWrite,
  output logic       ALUsrc,
  output logic       RegWrite
);
  ctrl_t nextCtrl;
  ctrl_t ctrlQ;
  control_decode u_decode (
    .opcode (opcode),
    .ctrl   (nextCtrl)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ctrlQ <= CTRL_NOP;
    else        ctrlQ <= nextCtrl;
  assign RegDst   = ctrlQ.RegDst;
  assign Branch   = ctrlQ.Branch;
  assign BranchNe = ctrlQ.BranchNe;
  assign MemRead  = ctrlQ.MemRead;
  assign MemtoReg = ctrlQ.MemtoReg;
  assign ALUop    = ctrlQ.ALUop;
  assign MemWrite = ctrlQ.MemWrite;
  assign ALUsrc   = ctrlQ.ALUsrc;
  assign RegWrite = ctrlQ.RegWrite;
endmodule

// File: tb/tb_mips_control.sv
// tb_mips_control: randomized scoreboard bench for mips_control against a rule-based model
module tb_mips_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic       RegDst, Branch, BranchNe, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite;
  logic [1:0] ALUop;
  int total = 0;
  int bad = 0;
  logic [9:0] sb[$];
  logic [5:0] legal[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000};

  mips_control dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .RegDst   (RegDst),
    .Branch   (Branch),
    .BranchNe (BranchNe),
    .MemRead  (MemRead),
    .MemtoReg (MemtoReg),
    .ALUop    (ALUop),
    .MemWrite (MemWrite),
    .ALUsrc   (ALUsrc),
    .RegWrite (RegWrite)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dutv();
    return {RegDst, ALUsrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, BranchNe, ALUop};
  endfunction

  // Model: classify the instruction, then derive each control from what the class does.
  function automatic logic [9:0] model(input logic [5:0] op);
    logic isR, isLoad, isStore, isBr, isAddi;
    logic [1:0] aop;
    if ($isunknown(op)) return 10'b0;
    isR     = op == 6'd0;
    isLoad  = op == 6'd35;
    isStore = op == 6'd43;
    isBr    = op == 6'd4 || op == 6'd5;
    isAddi  = op == 6'd8;
    aop     = isR ? 2'd2 : isBr ? 2'd1 : 2'd0;
    return {isR, isLoad | isStore | isAddi, isLoad, isR | isLoad | isAddi,
            isLoad, isStore, isBr, op == 6'd5, aop};
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b op=%b t=%0t", name, act, exp, opcode, $time);
    end
  endtask

  task automatic issue(input logic [5:0] op);
    @(negedge clk);
    opcode = op;
    sb.push_back(model(opcode));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("rd_wr_excl", {9'b0, MemRead & MemWrite}, 10'b0);
      chk("regwr_memwr_excl", {9'b0, RegWrite & MemWrite}, 10'b0);
      if (sb.size() != 0) chk("pipe", dutv(), sb.pop_front());
    end
  end

  initial begin
    logic [5:0] op;
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", dutv(), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(opcode));
    issue(6'b000000);
    issue(6'b100011);
    issue(6'b101011);
    issue(6'b000101);
    issue(6'b000100);
    issue(6'b001000);
    issue(6'b111111);
    issue(6'b000010);
    @(negedge clk);
    opcode = 6'bxxxxxx;
    sb.push_back(model(opcode));
    issue(6'b100011);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_clear", dutv(), 10'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("hold_after_release", dutv(), 10'b0);
    sb.push_back(model(opcode));
    for (int i = 0; i < 64; i++) issue(6'(i));
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 1) ? legal[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
      issue(op);
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
